// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC sequencing, branch redirect,
// stall/flush handling, HALT freeze and a saturating count of loaded instructions.
module fetch_stage #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 20,
    parameter logic [PC_WIDTH-1:0] PC_STEP     = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [4:0]          HALT_OPCODE = 5'b11111,
    parameter int                  COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   StallF,
    input  logic                   StallD,
    input  logic                   FlushD,
    input  logic                   BranchTaken,
    input  logic [PC_WIDTH-1:0]    BranchTarget,
    output logic [PC_WIDTH-1:0]    IMemAddr,
    input  logic [INSTR_WIDTH-1:0] IMemData,
    output logic [INSTR_WIDTH-1:0] InstructionD,
    output logic [PC_WIDTH-1:0]    PCD,
    output logic                   ValidD,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] FetchCount
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   pc;
    logic                  stall_f_eff;
    logic                  flush;
    logic                  load;
    logic                  halt_load;

    // StallD also holds the PC so the word at PCF is not skipped while decode is blocked.
    assign stall_f_eff = StallF | StallD;
    assign flush       = FlushD | BranchTaken;
    assign load        = (state == RUN) && !flush && !StallD;
    assign halt_load   = load && (IMemData[INSTR_WIDTH-1 -: 5] == HALT_OPCODE);

    assign IMemAddr = pc;
    assign Halted   = (state == HALTED);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            pc           <= RESET_PC;
            InstructionD <= '0;
            PCD          <= '0;
            ValidD       <= 1'b0;
            FetchCount   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (BranchTaken)
                        pc <= BranchTarget;
                    else if (!stall_f_eff && !halt_load)
                        pc <= pc + PC_STEP;

                    if (flush) begin
                        InstructionD <= '0;
                        PCD          <= '0;
                        ValidD       <= 1'b0;
                    end else if (!StallD) begin
                        InstructionD <= IMemData;
                        PCD          <= pc;
                        ValidD       <= 1'b1;
                    end

                    if (halt_load)
                        state <= HALTED;
                end
                HALTED: begin
                    // A branch here is an older instruction resolving; it restarts fetch.
                    if (BranchTaken) begin
                        pc    <= BranchTarget;
                        state <= RUN;
                    end
                    if (flush || !StallD) begin
                        InstructionD <= '0;
                        PCD          <= '0;
                        ValidD       <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase

            if (load && (FetchCount != '1))
                FetchCount <= FetchCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random stimulus,
// all compared against a cycle-level reference model of the fetch/IF-ID behaviour.
module tb_fetch_stage;

    localparam int PW = 8;
    localparam int IW = 20;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_f, stall_d, flush_d, branch_taken;
    logic [PW-1:0] branch_target;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instruction_d;
    logic [PW-1:0] pc_d;
    logic          valid_d, halted;
    logic [CW-1:0] fetch_count;

    logic [IW-1:0] rom [256];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [PW-1:0] m_pc;
    logic [IW-1:0] m_instr;
    logic [PW-1:0] m_pcd;
    logic          m_valid;
    logic          m_halted;
    int            m_count;

    fetch_stage #(
        .PC_WIDTH   (PW),
        .INSTR_WIDTH(IW),
        .PC_STEP    (8'd1),
        .RESET_PC   (8'd0),
        .HALT_OPCODE(5'b11111),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (stall_f),
        .StallD      (stall_d),
        .FlushD      (flush_d),
        .BranchTaken (branch_taken),
        .BranchTarget(branch_target),
        .IMemAddr    (imem_addr),
        .IMemData    (imem_data),
        .InstructionD(instruction_d),
        .PCD         (pc_d),
        .ValidD      (valid_d),
        .Halted      (halted),
        .FetchCount  (fetch_count)
    );

    always #5 clk = ~clk;
    assign imem_data = rom[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] word(input logic [4:0] op, input logic [14:0] rest);
        return {op, rest};
    endfunction

    task automatic check_outputs();
        check("instr",  32'(instruction_d), 32'(m_instr));
        check("pcd",    32'(pc_d),          32'(m_pcd));
        check("valid",  32'(valid_d),       32'(m_valid));
        check("halted", 32'(halted),        32'(m_halted));
        check("count",  32'(fetch_count),   32'(m_count));
        check("pcf",    32'(imem_addr),     32'(m_pc));
    endtask

    // One clock: apply inputs, predict the post-edge state, then compare.
    task automatic cycle(input logic rn, input logic stf, input logic std, input logic fl,
                         input logic bt, input logic [PW-1:0] tgt);
        logic [IW-1:0] w;
        logic          takes;
        logic          is_halt;
        @(negedge clk);
        rst_n = rn; stall_f = stf; stall_d = std; flush_d = fl;
        branch_taken = bt; branch_target = tgt;
        #1;
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        w       = rom[m_pc];
        takes   = !m_halted && !fl && !bt && !std;
        is_halt = takes && (w[IW-1:IW-5] == 5'h1f);
        if (!rn) begin
            m_pc = 0; m_instr = 0; m_pcd = 0; m_valid = 0; m_halted = 0; m_count = 0;
        end else begin
            if (takes) begin
                m_instr = w; m_pcd = m_pc; m_valid = 1;
                if (m_count < (1 << CW) - 1) m_count++;
            end else if (!(std && !fl && !bt)) begin
                m_instr = 0; m_pcd = 0; m_valid = 0;
            end
            if (bt)
                m_pc = tgt;
            else if (!m_halted && !stf && !std && !is_halt)
                m_pc = PW'((int'(m_pc) + 1) % 256);
            if (bt)
                m_halted = 0;
            else if (is_halt)
                m_halted = 1;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = word(5'h01, 15'(i));
        rom[0] = word(5'h02, 15'h0aaa);
        rom[1] = word(5'h03, 15'h0bbb);
        rom[2] = word(5'h04, 15'h0ccc);
        rom[3] = word(5'h05, 15'h0ddd);
        rom[5] = word(5'h1f, 15'h0000);
        rom[8'h10] = word(5'h06, 15'h1010);
        rom[8'h20] = word(5'h07, 15'h2020);
        rom[8'h21] = word(5'h1f, 15'h0021);

        rst_n = 0; stall_f = 0; stall_d = 0; flush_d = 0; branch_taken = 0; branch_target = 0;
        m_pc = 'x; m_instr = 'x; m_pcd = 'x; m_valid = 'x; m_halted = 'x; m_count = 0;
        // reset state
        cycle(0, 0, 0, 0, 0, 0);
        check("reset_valid", 32'(valid_d), 32'd0);

        // 1: straight-line fetch, one-cycle latency
        run(3);
        check("seq_count3", 32'(fetch_count), 32'd3);
        check("seq_instr_c", 32'(instruction_d), 32'(word(5'h04, 15'h0ccc)));

        // 2: stalls hold PC and IF/ID, then release
        cycle(1, 0, 0, 0, 1, 8'd1);
        run(1);
        for (int i = 0; i < 2; i++) cycle(1, 1, 1, 0, 0, 0);
        check("stall_pcd", 32'(pc_d), 32'd1);
        run(1);
        check("release_pcd", 32'(pc_d), 32'd2);
        for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, 0, 0);
        run(1);

        // 3: branch wins over stalls
        cycle(1, 1, 1, 0, 1, 8'h10);
        check("br_pcf", 32'(imem_addr), 32'h10);
        run(1);
        check("br_pcd", 32'(pc_d), 32'h10);

        // 4: HALT at address 5 freezes fetch
        cycle(1, 0, 0, 0, 1, 8'd4);
        run(2);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pcf", 32'(imem_addr), 32'd5);
        run(3);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);

        // 5: branch leaves HALTED; HALT under flush is dropped
        cycle(1, 0, 0, 0, 1, 8'h20);
        check("unhalt", 32'(halted), 32'd0);
        run(1);
        cycle(1, 0, 0, 1, 0, 0);
        check("flush_no_halt", 32'(halted), 32'd0);
        cycle(1, 0, 0, 0, 1, 8'h21);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 8'hff);

        // 6: counter saturation, PC wrap, then reset mid-stream
        run(20);
        check("sat_count", 32'(fetch_count), 32'd15);
        cycle(0, 0, 0, 0, 0, 0);
        check("rst_count", 32'(fetch_count), 32'd0);

        // random stimulus with a HALT-rich ROM
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 9) == 0) ? word(5'h1f, 15'($urandom))
                                                 : IW'($urandom);
        for (int i = 0; i < 3000; i++) begin
            logic rn;
            rn = ($urandom_range(0, 199) != 0);
            cycle(rn,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0,
                  PW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the SIMD AES core. Holds the PC, drives the instruction-memory address and captures the returned 20-bit instruction into the IF/ID register. That register feeds the decode-stage controller directly. Also handles stall, flush, branch redirect, a HALT opcode that freezes fetch, and a retired-fetch counter.

Parameters:
PC_WIDTH, 32, width of PC and memory address.
INSTR_WIDTH, 20, instruction width; opcode is bits [INSTR_WIDTH-1:INSTR_WIDTH-5].
PC_STEP, 1, PC increment (word-addressed memory).
RESET_PC, 0, PC value after reset.
HALT_OPCODE, 5'b11111, opcode that stops fetch.
COUNT_WIDTH, 16, width of FetchCount.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous reset, active-low.
StallF  in  1  hold PC.
StallD  in  1  hold IF/ID register.
FlushD  in  1  replace IF/ID contents with a bubble.
BranchTaken  in  1  redirect fetch to BranchTarget.
BranchTarget  in  PC_WIDTH  redirect address.
IMemAddr  out  PC_WIDTH  instruction memory address; equals PCF combinationally.
IMemData  in  INSTR_WIDTH  instruction word for IMemAddr, same cycle (asynchronous ROM).
InstructionD  out  INSTR_WIDTH  IF/ID instruction, to the decode controller.
PCD  out  PC_WIDTH  PC of InstructionD.
ValidD  out  1  InstructionD is a real instruction.
Halted  out  1  fetch frozen by HALT.
FetchCount  out  COUNT_WIDTH  count of valid instructions loaded into IF/ID; saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge) overrides everything:
  - PCF=RESET_PC, InstructionD=0, PCD=0, ValidD=0.
  - State RUN, Halted=0, FetchCount=0.
- Per-cycle signals:
  - stallF_eff = StallF | StallD. StallD without StallF must never lose an instruction.
  - flush = FlushD | BranchTaken.
- States: RUN, HALTED. Halted = (state==HALTED).
- PC update in RUN, first match wins:
  - BranchTaken: PCF<=BranchTarget.
  - stallF_eff: hold.
  - HALT is being loaded this cycle: hold.
  - Otherwise: PCF<=PCF+PC_STEP, modulo 2^PC_WIDTH (wraps silently).
- IF/ID update in RUN, first match wins:
  - flush: InstructionD<=0, PCD<=0, ValidD<=0.
  - StallD: hold.
  - Otherwise: InstructionD<=IMemData, PCD<=PCF, ValidD<=1.
- HALT detection:
  - A HALT is loaded when IMemData opcode==HALT_OPCODE and the IF/ID register loads it as valid.
  - That edge: state RUN->HALTED. The halt instruction is kept in IF/ID (ValidD=1). PCF stays at the halt's address.
- In HALTED:
  - PCF frozen.
  - IF/ID: flush -> bubble; StallD -> hold; otherwise -> bubble. No new instruction is ever loaded.
  - BranchTaken (an older branch resolving): PCF<=BranchTarget, IF/ID bubble, state->RUN; Halted low the next cycle.
  - FlushD alone does not leave HALTED.
- FetchCount:
  - +1 on each edge that loads a valid instruction into IF/ID, including the HALT.
  - Saturates at all-ones.
  - Bubbles and holds do not count.
- Latency: the instruction at PCF appears on InstructionD one cycle later.
- Simultaneous events:
  - BranchTaken with StallF/StallD: the branch wins on both PC and IF/ID.
  - FlushD with StallD: flush wins.
  - HALT fetched in the same cycle as BranchTaken or FlushD: not loaded, no state change.
- IMemData is sampled only on load edges; it is don't-care otherwise.

Test Plan:
1. Reset, then ROM[0..3]={A,B,C,D}, no stalls -> IMemAddr 0,1,2,3 on consecutive cycles; InstructionD/PCD = A/0, B/1, C/2 one cycle later; ValidD=1; FetchCount=3 after 3 loads.
2. StallF=StallD=1 for 2 cycles at PCF=2 -> PCF stays 2, InstructionD holds B/1, FetchCount unchanged. Release -> C/2 loads next edge. Repeat with StallD=1, StallF=0 -> same result (PC held).
3. BranchTaken=1, BranchTarget=0x10, with StallF=StallD=1 -> next edge: PCF=0x10, ValidD=0, InstructionD=0. Following edge: ROM[0x10] loaded with PCD=0x10.
4. ROM[5]=HALT (opcode 11111) -> after load: InstructionD=HALT, PCD=5, ValidD=1, Halted=1, PCF stays 5. Next edges: ValidD=0, FetchCount frozen.
5. While HALTED, BranchTaken=1, BranchTarget=0x20 -> PCF=0x20, Halted=0, ValidD=0. Next edge loads ROM[0x20]. Also: HALT at PCF with FlushD=1 -> not loaded, Halted stays 0.
6. COUNT_WIDTH=4, 20 unstalled fetches -> FetchCount reaches 15 and holds. rst_n=0 mid-stream -> PCF=0, ValidD=0, FetchCount=0, Halted=0 on that edge.
